// File: rtl/z80_io_bridge.sv
// Mailbox between Z80 I/O strobes and the PicoRV32 I/O window: each IN/OUT cycle
// is held in wait until firmware replies via RDATA or ACK.
module z80_io_bridge #(
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       z80_iord,
  input  logic       z80_iowr,
  input  logic [7:0] z80adr,
  input  logic [7:0] z80do,
  input  logic       z80hlt,
  output logic [7:0] z80di,
  output logic       z80_io_ready,
  input  logic       io_valid,
  input  logic [3:0] rv_adr,
  input  logic       rv_wstr,
  input  logic [7:0] rv_wdata,
  output logic [7:0] rv_rdata,
  output logic       rv_irq
);

  typedef enum logic [1:0] {IDLE, PENDING, DONE} state_t;

  state_t           state, state_nx;
  logic [7:0]       port_q, wdata_q, reply_q;
  logic             dir_q, overrun_q, valid_d;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      count_ext;
  logic             strobe, wr_first, cmpl_wr;

  assign strobe   = z80_iord | z80_iowr;
  // io_valid is held for two edges per access; only its first edge may act.
  assign wr_first = io_valid & rv_wstr & ~valid_d;
  assign cmpl_wr  = wr_first & ((rv_adr == 4'd3) || (rv_adr == 4'd4));

  assign z80_io_ready = (state == DONE);
  assign rv_irq       = (state == PENDING);
  assign z80di        = reply_q;
  assign count_ext    = 16'(count_q);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (strobe) state_nx = PENDING;
      PENDING: if (cmpl_wr) state_nx = DONE;
      DONE:    if (!strobe) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      port_q    <= 8'h00;
      wdata_q   <= 8'h00;
      dir_q     <= 1'b0;
      reply_q   <= 8'hFF;
      count_q   <= '0;
      overrun_q <= 1'b0;
      valid_d   <= 1'b0;
    end else begin
      valid_d <= io_valid;
      if (state == IDLE && strobe) begin
        port_q  <= z80adr;
        wdata_q <= z80do;
        dir_q   <= z80_iowr;
      end
      // An RDATA write during an OUT cycle behaves as a plain ACK.
      if (state == PENDING && cmpl_wr) begin
        count_q <= count_q + CNT_W'(1);
        if (!dir_q)
          reply_q <= (rv_adr == 4'd3) ? rv_wdata : 8'hFF;
      end
      if (cmpl_wr && state != PENDING)
        overrun_q <= 1'b1;
      else if (wr_first && rv_adr == 4'd0 && rv_wdata[3])
        overrun_q <= 1'b0;
    end
  end

  always_comb begin
    rv_rdata = 8'h00;
    case (rv_adr)
      4'd0: rv_rdata = {4'b0000, overrun_q, z80hlt, dir_q, state == PENDING};
      4'd1: rv_rdata = port_q;
      4'd2: rv_rdata = wdata_q;
      4'd5: rv_rdata = count_ext[7:0];
      4'd6: rv_rdata = count_ext[15:8];
      default: rv_rdata = 8'h00;
    endcase
  end

endmodule
